// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end: word width, opcodes
// and the fetch FSM state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HLT   = 6'h3f;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and imem (slave).
// Handshake: imem_req stays high with a stable imem_addr until the cycle imem_ack
// is high; imem_rdata is valid only in that cycle, and an ack without a request is ignored.
interface instr_fetch_if;
    import mips_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC select for a retiring non-halt instruction:
// jump beats a taken branch, which beats the sequential path.
module next_pc
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic [WORD_W-1:0] instr,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    output logic [WORD_W-1:0] target
);

    logic [WORD_W-1:0] jump_tgt;
    logic [WORD_W-1:0] branch_tgt;
    logic [WORD_W-1:0] branch_off;
    logic              unused_opcode;

    assign jump_tgt   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_tgt = pc_plus4 + branch_off;

    // The opcode field is decoded upstream; only the immediates matter here.
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        target = pc_plus4;
        if (jump) begin
            target = jump_tgt;
        end else if (branch && zero) begin
            target = branch_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads one instruction word per retire over the
// imem handshake, and stops for good on halt or on an imem timeout.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16,
    parameter int          CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    output logic [WORD_W-1:0]    instr,
    output logic [5:0]           opcode,
    output logic                 instr_valid,
    output logic [WORD_W-1:0]    pc,
    output logic [WORD_W-1:0]    pc_plus4,
    input  logic                 retire,
    input  logic                 jump,
    input  logic                 branch,
    input  logic                 zero,
    input  logic                 halt,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [CNT_W-1:0]     retired_cnt,
    output fetch_state_t         dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [WORD_W-1:0] target;

    next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .target   (target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        ret_cnt_d = ret_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_ISSUE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (retire) begin
                    if (halt) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d      = target;
                        ret_cnt_d = ret_cnt_q + 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_WAIT);
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = (state_q == S_ISSUE);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign halted      = (state_q == S_HALTED);
    assign fetch_err   = err_q;
    assign retired_cnt = ret_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances share all stimulus, one at the
// default reset PC and one reset to 0x4000_0000 for the jump-region case.
module tb_instr_fetch;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic retire = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0, halt = 1'b0;
    logic ack = 1'b0;
    logic [31:0] rdata = '0;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_if if_a ();
    instr_fetch_if if_b ();

    assign if_a.imem_ack   = ack;
    assign if_a.imem_rdata = rdata;
    assign if_b.imem_ack   = ack;
    assign if_b.imem_rdata = rdata;

    logic [31:0]  instr_a, pc_a, pc4_a, instr_b, pc_b, pc4_b, cnt_a, cnt_b;
    logic [5:0]   op_a, op_b;
    logic         iv_a, halted_a, err_a, iv_b, halted_b, err_b;
    fetch_state_t dbg_a, dbg_b;

    instr_fetch u_dut (
        .clk (clk), .reset (reset), .imem (if_a),
        .instr (instr_a), .opcode (op_a), .instr_valid (iv_a),
        .pc (pc_a), .pc_plus4 (pc4_a),
        .retire (retire), .jump (jump), .branch (branch), .zero (zero), .halt (halt),
        .halted (halted_a), .fetch_err (err_a), .retired_cnt (cnt_a), .dbg_state (dbg_a)
    );

    instr_fetch #(.RESET_PC(32'h4000_0000)) u_dut_hi (
        .clk (clk), .reset (reset), .imem (if_b),
        .instr (instr_b), .opcode (op_b), .instr_valid (iv_b),
        .pc (pc_b), .pc_plus4 (pc4_b),
        .retire (retire), .jump (jump), .branch (branch), .zero (zero), .halt (halt),
        .halted (halted_b), .fetch_err (err_b), .retired_cnt (cnt_b), .dbg_state (dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance on falling edges until the FSM reaches state s (bounded).
    task automatic wait_for(input fetch_state_t s, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dbg_a == s) found = 1'b1;
            else @(negedge clk);
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic serve(input logic [31:0] word, input string tag);
        wait_for(S_WAIT, tag);
        ack   = 1'b1;
        rdata = word;
        @(negedge clk);
        ack   = 1'b0;
        rdata = '0;
    endtask

    task automatic do_retire(input logic j, input logic b, input logic z, input logic h);
        retire = 1'b1; jump = j; branch = b; zero = z; halt = h;
        @(negedge clk);
        retire = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0;
    endtask

    initial begin
        bit req_seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", pc_a, 32'h0);
        check("rst_pc_hi", pc_b, 32'h4000_0000);
        check("rst_instr", instr_a, 32'h0);
        check("rst_valid", {31'd0, iv_a}, 32'd0);
        check("rst_req", {31'd0, if_a.imem_req}, 32'd0);
        check("rst_halted", {31'd0, halted_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_cnt", cnt_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("req_after_idle", {31'd0, if_a.imem_req}, 32'd1);
        check("addr_after_idle", if_a.imem_addr, 32'h0);

        // Jump with branch+zero also high: jump wins, upper nibble from pc+4
        serve(32'h0800_0040, "t3_serve");
        check("t3_pc_hi", pc_b, 32'h4000_0000);
        check("t3_op", {26'd0, op_b}, {26'd0, OP_J});
        do_retire(1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_addr_hi", if_b.imem_addr, 32'h4000_0100);
        check("t3_addr_lo", if_a.imem_addr, 32'h0000_0100);
        check("t3_req_lat", {31'd0, if_a.imem_req}, 32'd1);

        // Reset in WAIT together with an ack: ack must not be latched
        wait_for(S_WAIT, "t6_wait");
        reset = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t6_instr", instr_a, 32'h0);
        check("t6_pc", pc_a, 32'h0);
        check("t6_cnt", cnt_a, 32'd0);
        check("t6_valid", {31'd0, iv_a}, 32'd0);
        reset = 1'b0; ack = 1'b0; rdata = '0;
        @(negedge clk);
        check("t6_restart_req", {31'd0, if_a.imem_req}, 32'd1);
        check("t6_restart_addr", if_a.imem_addr, 32'h0);

        // addi, sequential retire
        serve(32'h2008_0005, "t1_serve");
        check("t1_valid", {31'd0, iv_a}, 32'd1);
        check("t1_op", {26'd0, op_a}, {26'd0, OP_ADDI});
        check("t1_pc", pc_a, 32'h0);
        check("t1_instr", instr_a, 32'h2008_0005);
        do_retire(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_addr", if_a.imem_addr, 32'h4);
        check("t1_cnt", cnt_a, 32'd1);
        check("t1_valid_drop", {31'd0, iv_a}, 32'd0);

        // Jump to 0x10
        serve(32'h0800_0004, "j10_serve");
        do_retire(1'b1, 1'b0, 1'b0, 1'b0);
        check("j10_addr", if_a.imem_addr, 32'h10);

        // beq imm=3 taken: 0x14 + 12
        serve(32'h1000_0003, "t2_serve");
        check("t2_pc4", pc4_a, 32'h14);
        do_retire(1'b0, 1'b1, 1'b1, 1'b0);
        check("t2_taken", if_a.imem_addr, 32'h20);
        // Backward branch imm=-5: 0x24 - 20 = 0x10
        serve(32'h1000_FFFB, "t2_back_serve");
        do_retire(1'b0, 1'b1, 1'b1, 1'b0);
        check("t2_back", if_a.imem_addr, 32'h10);
        serve(32'h1000_0003, "t2_nt_serve");
        do_retire(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_not_taken", if_a.imem_addr, 32'h14);
        check("t2_cnt", cnt_a, 32'd5);

        // Branch imm=-7 from 0x14: 0x18 - 28 = 0xFFFF_FFFC, then wrap to 0
        serve(32'h1000_FFF9, "wrap_br_serve");
        do_retire(1'b0, 1'b1, 1'b1, 1'b0);
        check("wrap_top", if_a.imem_addr, 32'hFFFF_FFFC);
        serve(32'h2008_0005, "wrap_serve");
        check("wrap_pc4", pc4_a, 32'h0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_addr", if_a.imem_addr, 32'h0);
        check("wrap_cnt", cnt_a, 32'd7);

        // Halt: terminal, pc and count frozen, no more requests
        serve(32'hFC00_0000, "t4_serve");
        check("t4_op", {26'd0, op_a}, {26'd0, OP_HLT});
        do_retire(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_halted", {31'd0, halted_a}, 32'd1);
        check("t4_valid", {31'd0, iv_a}, 32'd0);
        check("t4_pc", pc_a, 32'h0);
        check("t4_cnt", cnt_a, 32'd7);
        check("t4_err", {31'd0, err_a}, 32'd0);
        req_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (if_a.imem_req) req_seen = 1'b1;
            @(negedge clk);
        end
        check("t4_no_req", {31'd0, req_seen}, 32'd0);
        check("t4_still_halted", {31'd0, halted_a}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_pc", pc_a, 32'h0);
        check("t4_rst_halted", {31'd0, halted_a}, 32'd0);
        check("t4_rst_cnt", cnt_a, 32'd0);
        reset = 1'b0;

        // Timeout: 16 WAIT cycles without ack
        wait_for(S_WAIT, "t5_wait");
        repeat (15) @(negedge clk);
        check("t5_err_early", {31'd0, err_a}, 32'd0);
        check("t5_req_held", {31'd0, if_a.imem_req}, 32'd1);
        @(negedge clk);
        check("t5_err", {31'd0, err_a}, 32'd1);
        check("t5_halted", {31'd0, halted_a}, 32'd1);
        check("t5_req_off", {31'd0, if_a.imem_req}, 32'd0);
        ack = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        ack = 1'b0; rdata = '0;
        @(negedge clk);
        check("t5_late_instr", instr_a, 32'h0);
        check("t5_late_valid", {31'd0, iv_a}, 32'd0);
        check("t5_late_state", {29'd0, dbg_a}, {29'd0, S_HALTED});
        check("t5_err_sticky", {31'd0, err_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
